eth_decap: RTL and testbench
============================

# eth_decap

Receive-side decapsulator for the TLP-over-Ethernet tap link. It sits between the 10G Ethernet MAC's AXI4-Stream RX master and a TLP output FIFO, all in the `clk156` domain. It validates the header of each received frame, strips the 16-byte encapsulation header and writes the TLP payload beats as 76-bit FIFO entries. Entries use the same layout the transmit path arbitrates on.

## Interface
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01: accepted destination MAC. `LOCAL_MAC[47:40]` is wire byte 0.
- `ETHERTYPE`, default 16'h88B5: required EtherType.
- `PROMISC`, default 0: when 1, the destination MAC check is skipped.
- `clk156`  in  1  core clock, 156.25 MHz. Single clock for the whole block.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `s_axis_tvalid`  in  1  MAC RX beat valid. There is no tready; every valid beat must be consumed.
- `s_axis_tdata`  in  64  RX data. Wire byte k is in bits [8k+7:8k].
- `s_axis_tkeep`  in  8  byte enables.
- `s_axis_tlast`  in  1  last beat of the frame.
- `s_axis_tuser`  in  1  frame good. Meaningful only when tlast=1; 0 means bad FCS or error.
- `wr_en`  out  1  FIFO write strobe.
- `din`  out  76  FIFO entry, laid out as {src_id[1:0], err, tlast, tkeep[7:0], tdata[63:0]}.
- `full`  in  1  FIFO programmable-full. It must assert with at least 2 free entries remaining.
- `frame_ok_cnt`  out  32  count of frames delivered clean. Wraps.
- `frame_drop_cnt`  out  32  count of frames rejected or error-marked. Wraps.
- `ovf_cnt`  out  32  count of frames truncated by FIFO full. Wraps.

## Operation
- Frame layout:
  - Beat 0: bytes 0–5 are the destination MAC; bytes 6–7 are the first two source-MAC bytes.
  - Beat 1: bytes 0–3 are the rest of the source MAC; bytes 4–5 are the EtherType (byte 4 is the MSB); byte 6 is the shim src_id, of which only [1:0] is used; byte 7 is flags and is ignored.
  - Beat 2 onward: TLP payload, copied verbatim.
- States: HDR0, HDR1, PAYLOAD, DISCARD, TERM. All transitions occur only on `s_axis_tvalid`, except TERM.
- HDR0:
  - Mismatch condition: the destination MAC does not equal `LOCAL_MAC` and `PROMISC`=0.
  - On mismatch or tlast: `frame_drop_cnt`+1. Go to DISCARD, or stay in HDR0 if tlast.
  - On a match without tlast, go to HDR1.
- HDR1:
  - Reject condition: EtherType ≠ `ETHERTYPE`, or tlast.
  - On reject: drop +1. Go to DISCARD, or to HDR0 if tlast.
  - Otherwise: latch src_id; if `full`=1, `ovf_cnt`+1 and go to DISCARD; otherwise go to PAYLOAD.
- PAYLOAD, normal beat (`full`=0):
  - Register one entry: data, keep, tlast, src_id, err = tlast & ~tuser.
  - On a tlast beat: if tuser=1, `frame_ok_cnt`+1; otherwise `frame_drop_cnt`+1. Then go to HDR0.
- PAYLOAD, beat arriving while `full`=1:
  - The beat is not written. `ovf_cnt`+1.
  - If the beat has tlast, go to TERM; otherwise go to DISCARD with the terminator-pending flag set.
- DISCARD:
  - Ignore beats until tlast.
  - On tlast, go to TERM if terminator-pending, otherwise to HDR0.
- TERM:
  - When `full`=0, write one terminator entry: tlast=1, err=1, tkeep=0, tdata=0, latched src_id. Then go to HDR0.
  - Frames that start while in TERM are discarded. A beat arriving in TERM sets a dropping flag: drop +1 at that frame's first beat; its remaining beats are ignored until tlast.
- Counters increment at most once per frame.

## Timing
- Reset (`sys_rst_n`=0 at a clk156 edge):
  - State becomes HDR0.
  - `wr_en`=0, `din`=0, all counters 0, latched src_id 0, terminator-pending flag 0.
- Reset release is frame-aligned because the MAC RX path shares the same reset.
- Latency: a payload beat valid at cycle t produces `wr_en`=1 with its entry at cycle t+1. `wr_en` is registered.
- `full` is sampled in the cycle the beat is on `s_axis`. The 2-entry margin on `full` covers the registered write.
- Back-to-back frames with zero idle cycles are supported: the cycle after a tlast beat may be a HDR0 beat.
- Gaps (tvalid=0) at any point leave the state and outputs held; `wr_en` is 0 in the following cycle.
- Minimum delivered frame is 3 beats.
- Counters update at t+1 relative to the deciding beat.

## Test plan
- Good frame, 2 header beats + 3 payload beats, last beat tkeep=8'h0F, src_id=2, tuser=1:
  - Expect 3 writes at t+1.
  - Last entry has tlast=1, err=0, keep=0F, din[75:74]=2.
  - `frame_ok_cnt`=1.
- Three frames: one with wrong destination MAC, one with EtherType 16'h0800, one with tlast on beat 1:
  - Expect zero writes.
  - `frame_drop_cnt`=3.
- PROMISC=1, frame with destination 48'hFFFFFFFFFFFF: expect delivery.
- Good-header frame ending with tuser=0: expect all beats written, last entry err=1, `frame_drop_cnt`=1.
- `full` asserted on payload beat 2 of 4, then released 5 cycles after the frame's tlast:
  - Exactly 1 payload entry written.
  - Then 1 terminator entry {err=1, tlast=1, keep=0}.
  - `ovf_cnt`=1.
- Two good frames back-to-back with no idle, then `sys_rst_n` pulsed low for 1 cycle mid-stream of idle:
  - Both frames delivered with correct tlast boundaries.
  - After reset, all counters read 0 and `wr_en`=0.

Source files
------------

// File: rtl/eth_decap_if.sv
// ---------------------------------------------------------------------------
// eth_decap_if
// Bundles the two streaming sides of the TLP-over-Ethernet receive
// decapsulator, which share the clk156 domain:
//   s_axis_*  MAC RX AXI4-Stream beats. There is no tready, so every valid
//             beat is consumed.
//   wr_en/din TLP output FIFO write port. The entry is
//             {src_id[1:0], err, tlast, tkeep[7:0], tdata[63:0]}.
//   full      FIFO programmable-full. It asserts with at least 2 entries
//             still free.
// Modports:
//   slave   the decapsulator. It consumes the RX beats and drives the FIFO
//           write.
//   master  the surroundings. They drive the RX beats and full, and they
//           observe the FIFO write.
// ---------------------------------------------------------------------------
interface eth_decap_if;
  logic        s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        wr_en;
  logic [75:0] din;
  logic        full;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
           s_axis_tuser, full,
    output wr_en, din
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
           s_axis_tuser, full,
    input  wr_en, din
  );
endinterface

// File: rtl/eth_decap.sv
// ---------------------------------------------------------------------------
// eth_decap
// Receive-side decapsulator for the TLP-over-Ethernet tap link. For each
// frame it checks the destination MAC and the EtherType, strips the 16-byte
// encapsulation header (two beats), and writes the TLP payload beats into
// the output FIFO. A write is registered: a beat at cycle t is written at
// t+1.
// If the FIFO fills partway through a delivered frame, the frame is cut
// short. A terminator entry (err=1, tlast=1, tkeep=0) is then written, so
// that the consumer never sees an open TLP.
// Ports:
//   clk156          core clock (156.25 MHz), the only clock
//   sys_rst_n       synchronous active-low reset
//   bus             eth_decap_if slave: MAC RX stream in, FIFO write out
//   frame_ok_cnt    frames delivered clean (wraps)
//   frame_drop_cnt  frames rejected or error-marked (wraps)
//   ovf_cnt         frames truncated or refused because of FIFO full (wraps)
// ---------------------------------------------------------------------------
module eth_decap #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter bit          PROMISC   = 1'b0
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  eth_decap_if.slave  bus,
  output logic [31:0] frame_ok_cnt,
  output logic [31:0] frame_drop_cnt,
  output logic [31:0] ovf_cnt
);

  typedef enum logic [2:0] {HDR0, HDR1, PAYLOAD, DISCARD, TERM} state_t;

  state_t      state_q, state_d;
  logic [1:0]  src_id_q, src_id_d;
  logic        term_pend_q, term_pend_d;   // truncated frame still running; terminator owed at its tlast
  logic        drop_flag_q, drop_flag_d;   // frame that began during TERM is mid-flight
  logic        wr_en_q, wr_en_d;
  logic [75:0] din_q, din_d;
  logic        inc_ok, inc_drop, inc_ovf;

  logic [47:0] dst_mac;
  logic [15:0] eth_type;
  logic        dst_miss;

  // Wire byte 0 is the most significant byte of a MAC address, and it also
  // lands in the low byte lane of tdata, so the lanes are reversed here.
  assign dst_mac  = {bus.s_axis_tdata[7:0],   bus.s_axis_tdata[15:8],
                     bus.s_axis_tdata[23:16], bus.s_axis_tdata[31:24],
                     bus.s_axis_tdata[39:32], bus.s_axis_tdata[47:40]};
  assign eth_type = {bus.s_axis_tdata[39:32], bus.s_axis_tdata[47:40]};
  assign dst_miss = (dst_mac != LOCAL_MAC) && !PROMISC;

  always_comb begin
    // NOTE: every signal this block writes gets a default first. A path that
    // left one unassigned would infer a latch.
    state_d     = state_q;
    src_id_d    = src_id_q;
    term_pend_d = term_pend_q;
    drop_flag_d = drop_flag_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    inc_ok      = 1'b0;
    inc_drop    = 1'b0;
    inc_ovf     = 1'b0;

    unique case (state_q)
      HDR0: begin
        if (bus.s_axis_tvalid) begin
          if (dst_miss || bus.s_axis_tlast) begin
            inc_drop = 1'b1;
            state_d  = bus.s_axis_tlast ? HDR0 : DISCARD;
          end else begin
            state_d = HDR1;
          end
        end
      end

      HDR1: begin
        if (bus.s_axis_tvalid) begin
          if ((eth_type != ETHERTYPE) || bus.s_axis_tlast) begin
            inc_drop = 1'b1;
            state_d  = bus.s_axis_tlast ? HDR0 : DISCARD;
          end else begin
            src_id_d = bus.s_axis_tdata[49:48];
            // Nothing has been written yet, so a refused frame needs no
            // terminator.
            if (bus.full) begin
              inc_ovf = 1'b1;
              state_d = DISCARD;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
      end

      PAYLOAD: begin
        if (bus.s_axis_tvalid) begin
          // full is sampled with the beat. The 2-entry margin on full
          // absorbs the write that is already in the output register.
          if (!bus.full) begin
            wr_en_d = 1'b1;
            din_d   = {src_id_q, bus.s_axis_tlast & ~bus.s_axis_tuser,
                       bus.s_axis_tlast, bus.s_axis_tkeep, bus.s_axis_tdata};
            if (bus.s_axis_tlast) begin
              inc_ok   = bus.s_axis_tuser;
              inc_drop = ~bus.s_axis_tuser;
              state_d  = HDR0;
            end
          end else begin
            inc_ovf = 1'b1;
            if (bus.s_axis_tlast) begin
              state_d = TERM;
            end else begin
              state_d     = DISCARD;
              term_pend_d = 1'b1;
            end
          end
        end
      end

      DISCARD: begin
        if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
          state_d     = term_pend_q ? TERM : HDR0;
          term_pend_d = 1'b0;
        end
      end

      TERM: begin
        // A beat seen here belongs to a frame that started before the
        // terminator could be written. That frame is dropped and is counted
        // once, at its first beat.
        if (bus.s_axis_tvalid) begin
          inc_drop    = ~drop_flag_q;
          drop_flag_d = ~bus.s_axis_tlast;
        end
        if (!bus.full) begin
          wr_en_d     = 1'b1;
          din_d       = {src_id_q, 1'b1, 1'b1, 8'h00, 64'h0};
          state_d     = drop_flag_d ? DISCARD : HDR0;
          drop_flag_d = 1'b0;
        end
      end

      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk156) begin
    // NOTE: state updates use non-blocking assignments. Every register then
    // samples values from before the edge, whatever order they are written
    // in here.
    if (!sys_rst_n) begin
      // NOTE: din is cleared along with the control state. It is only
      // 76 flops and not a memory, so a defined reset value costs nothing.
      state_q        <= HDR0;
      src_id_q       <= 2'd0;
      term_pend_q    <= 1'b0;
      drop_flag_q    <= 1'b0;
      wr_en_q        <= 1'b0;
      din_q          <= '0;
      frame_ok_cnt   <= 32'd0;
      frame_drop_cnt <= 32'd0;
      ovf_cnt        <= 32'd0;
    end else begin
      state_q        <= state_d;
      src_id_q       <= src_id_d;
      term_pend_q    <= term_pend_d;
      drop_flag_q    <= drop_flag_d;
      wr_en_q        <= wr_en_d;
      din_q          <= din_d;
      frame_ok_cnt   <= frame_ok_cnt   + {31'd0, inc_ok};
      frame_drop_cnt <= frame_drop_cnt + {31'd0, inc_drop};
      ovf_cnt        <= ovf_cnt        + {31'd0, inc_ovf};
    end
  end

  assign bus.wr_en = wr_en_q;
  assign bus.din   = din_q;

endmodule

// File: tb/tb_eth_decap.sv
// ---------------------------------------------------------------------------
// tb_eth_decap
// Bench for eth_decap. It runs two instances side by side on the same
// stimulus: dut0 (PROMISC=0) and dut1 (PROMISC=1).
// A frame-level reference model predicts the FIFO writes and the counters
// for each instance. One compare process checks both instances against the
// model on every cycle. Hand-computed literal checks after each directed
// scenario pin down the model itself.
// ---------------------------------------------------------------------------
module tb_eth_decap;
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETHERTYPE = 16'h88B5;

  logic        clk156 = 1'b0;
  logic        rst_n;
  logic        tvalid, tlast, tuser, full;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [31:0] ok0, drop0, ovf0, ok1, drop1, ovf1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #3 clk156 = ~clk156;

  eth_decap_if bus0 ();
  eth_decap_if bus1 ();

  assign bus0.s_axis_tvalid = tvalid;
  assign bus0.s_axis_tdata  = tdata;
  assign bus0.s_axis_tkeep  = tkeep;
  assign bus0.s_axis_tlast  = tlast;
  assign bus0.s_axis_tuser  = tuser;
  assign bus0.full          = full;
  assign bus1.s_axis_tvalid = tvalid;
  assign bus1.s_axis_tdata  = tdata;
  assign bus1.s_axis_tkeep  = tkeep;
  assign bus1.s_axis_tlast  = tlast;
  assign bus1.s_axis_tuser  = tuser;
  assign bus1.full          = full;

  eth_decap #(.LOCAL_MAC(LOCAL_MAC), .ETHERTYPE(ETHERTYPE), .PROMISC(1'b0)) dut0 (
    .clk156(clk156), .sys_rst_n(rst_n), .bus(bus0),
    .frame_ok_cnt(ok0), .frame_drop_cnt(drop0), .ovf_cnt(ovf0));

  eth_decap #(.LOCAL_MAC(LOCAL_MAC), .ETHERTYPE(ETHERTYPE), .PROMISC(1'b1)) dut1 (
    .clk156(clk156), .sys_rst_n(rst_n), .bus(bus1),
    .frame_ok_cnt(ok1), .frame_drop_cnt(drop1), .ovf_cnt(ovf1));

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-position based) ----------------
  logic        exp_wr[2];
  logic [75:0] exp_din[2];
  logic [31:0] exp_ok[2], exp_drop[2], exp_ovf[2];
  int          pos[2];          // beat index within the current frame
  bit          ign[2];          // rest of the current frame produces nothing
  bit          trunc[2];        // current frame was cut by full
  bit          owe[2];          // terminator owed, waiting for full=0
  bit          blk[2];          // current frame began while a terminator was owed
  logic [1:0]  sid[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_wr[k] = 0; exp_din[k] = '0; exp_ok[k] = 0; exp_drop[k] = 0; exp_ovf[k] = 0;
      pos[k] = 0; ign[k] = 0; trunc[k] = 0; owe[k] = 0; blk[k] = 0; sid[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit promisc);
    bit owed_at_start;
    bit miss;
    owed_at_start = owe[k];
    exp_wr[k] = 1'b0;
    if (owed_at_start && !full) begin
      exp_wr[k]  = 1'b1;
      exp_din[k] = {sid[k], 1'b1, 1'b1, 8'h00, 64'h0};
      owe[k]     = 1'b0;
    end
    if (tvalid) begin
      if (blk[k]) begin
        // ignored
      end else if (owed_at_start && pos[k] == 0) begin
        blk[k] = 1'b1;
        exp_drop[k]++;
      end else if (ign[k]) begin
        // ignored
      end else if (pos[k] == 0) begin
        miss = 1'b0;
        for (int b = 0; b < 6; b++)
          if (tdata[8*b +: 8] != LOCAL_MAC[8*(5-b) +: 8]) miss = 1'b1;
        if ((miss && !promisc) || tlast) begin
          exp_drop[k]++;
          ign[k] = 1'b1;
        end
      end else if (pos[k] == 1) begin
        if ({tdata[39:32], tdata[47:40]} != ETHERTYPE || tlast) begin
          exp_drop[k]++;
          ign[k] = 1'b1;
        end else begin
          sid[k] = tdata[49:48];
          if (full) begin
            exp_ovf[k]++;
            ign[k] = 1'b1;
          end
        end
      end else begin
        if (full) begin
          exp_ovf[k]++;
          ign[k]   = 1'b1;
          trunc[k] = 1'b1;
        end else begin
          exp_wr[k]  = 1'b1;
          exp_din[k] = {sid[k], tlast & ~tuser, tlast, tkeep, tdata};
          if (tlast) begin
            if (tuser) exp_ok[k]++;
            else       exp_drop[k]++;
          end
        end
      end
      if (tlast) begin
        pos[k] = 0; ign[k] = 0; blk[k] = 0;
        if (trunc[k]) begin
          owe[k]   = 1'b1;
          trunc[k] = 1'b0;
        end
      end else begin
        pos[k]++;
      end
    end
  endtask

  always @(posedge clk156) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  // ---------------- single compare process ----------------
  always @(negedge clk156) begin
    if (chk_en) begin
      check("wr_en0", {75'd0, bus0.wr_en}, {75'd0, exp_wr[0]});
      if (exp_wr[0]) check("din0", bus0.din, exp_din[0]);
      check("ok0",   {44'd0, ok0},   {44'd0, exp_ok[0]});
      check("drop0", {44'd0, drop0}, {44'd0, exp_drop[0]});
      check("ovf0",  {44'd0, ovf0},  {44'd0, exp_ovf[0]});
      check("wr_en1", {75'd0, bus1.wr_en}, {75'd0, exp_wr[1]});
      if (exp_wr[1]) check("din1", bus1.din, exp_din[1]);
      check("ok1",   {44'd0, ok1},   {44'd0, exp_ok[1]});
      check("drop1", {44'd0, drop1}, {44'd0, exp_drop[1]});
      check("ovf1",  {44'd0, ovf1},  {44'd0, exp_ovf[1]});
    end
  end

  // Write logs for the literal checks.
  logic [75:0] wq0[$];
  logic [75:0] wq1[$];
  always @(negedge clk156) begin
    if (bus0.wr_en === 1'b1) wq0.push_back(bus0.din);
    if (bus1.wr_en === 1'b1) wq1.push_back(bus1.din);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] hdr0(input logic [47:0] dst);
    logic [63:0] d;
    d = '0;
    for (int b = 0; b < 6; b++) d[8*b +: 8] = dst[8*(5-b) +: 8];
    d[63:48] = 16'h0B0A;
    return d;
  endfunction

  function automatic logic [63:0] hdr1(input logic [15:0] et, input logic [1:0] s);
    logic [63:0] d;
    d[31:0]  = 32'h4433_2211;
    d[39:32] = et[15:8];
    d[47:40] = et[7:0];
    d[55:48] = {6'b111111, s};    // upper src_id bits must be ignored
    d[63:56] = 8'h5A;
    return d;
  endfunction

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic u, input logic f);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u; full = f;
    @(negedge clk156);
  endtask

  task automatic idle(input int n, input logic f);
    tvalid = 1'b0; tdata = '0; tkeep = 8'h00; tlast = 1'b0; tuser = 1'b0; full = f;
    repeat (n) @(negedge clk156);
  endtask

  localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] P2 = 64'h0000_0000_A5A5_5A5A;
  localparam logic [63:0] P3 = 64'h1111_2222_3333_4444;

  int          n0, n1;
  logic [75:0] e;

  initial begin
    rst_n = 1'b0;
    idle(1, 1'b0);
    idle(2, 1'b0);
    check("rst_wr_en", {75'd0, bus0.wr_en}, 76'd0);
    check("rst_din", bus0.din, 76'd0);
    check("rst_cnts", {ok0[7:0], drop0[7:0], ovf0[7:0]}, 76'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    idle(2, 1'b0);

    // 1. good frame, 3 payload beats, last keep 0F, src_id 2
    n0 = wq0.size();
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd2), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 0, 0, 0);
    beat(P2, 8'h0F, 1, 1, 0);
    idle(3, 1'b0);
    check("good_nwrites", 76'(wq0.size() - n0), 76'd3);
    e = wq0[wq0.size()-1];
    check("good_last_entry", e, {2'd2, 1'b0, 1'b1, 8'h0F, P2});
    check("good_ok_cnt", {44'd0, ok0}, 76'd1);

    // 2. wrong dst, wrong EtherType, tlast on beat 1
    n0 = wq0.size();
    beat(hdr0(48'h02_00_00_00_00_02), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd1), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 1, 1, 0);
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(16'h0800, 2'd1), 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 1, 1, 0);
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd1), 8'hFF, 1, 1, 0);
    idle(3, 1'b0);
    check("bad_nwrites", 76'(wq0.size() - n0), 76'd0);
    check("bad_drop_cnt", {44'd0, drop0}, 76'd3);

    // 3. broadcast dst: only the promiscuous instance delivers
    n0 = wq0.size(); n1 = wq1.size();
    beat(hdr0(48'hFFFF_FFFF_FFFF), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd3), 8'hFF, 0, 0, 0);
    beat(P3, 8'hFF, 0, 0, 0);
    beat(P2, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 1, 1, 0);
    idle(3, 1'b0);
    check("promisc_nwrites", 76'(wq1.size() - n1), 76'd3);
    check("promisc_last", wq1[wq1.size()-1], {2'd3, 1'b0, 1'b1, 8'hFF, P1});
    check("nonpromisc_nwrites", 76'(wq0.size() - n0), 76'd0);
    check("nonpromisc_drop", {44'd0, drop0}, 76'd4);

    // 4. good header, tuser=0 on the last beat
    n0 = wq0.size();
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd1), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 0, 0, 0);
    beat(P2, 8'h03, 1, 0, 0);
    idle(3, 1'b0);
    check("err_nwrites", 76'(wq0.size() - n0), 76'd3);
    check("err_last", wq0[wq0.size()-1], {2'd1, 1'b1, 1'b1, 8'h03, P2});
    check("err_drop_cnt", {44'd0, drop0}, 76'd5);

    // 5. full from payload beat 2 of 4, released 5 cycles after tlast
    n0 = wq0.size();
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd1), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 0, 0, 1);
    beat(P2, 8'hFF, 0, 0, 1);
    beat(P3, 8'hFF, 1, 1, 1);
    idle(5, 1'b1);
    idle(3, 1'b0);
    check("ovf_nwrites", 76'(wq0.size() - n0), 76'd2);
    check("ovf_payload", wq0[n0], {2'd1, 1'b0, 1'b0, 8'hFF, P0});
    check("ovf_term", wq0[n0+1], {2'd1, 1'b1, 1'b1, 8'h00, 64'h0});
    check("ovf_cnt", {44'd0, ovf0}, 76'd1);

    // 6. truncation on the tlast beat, then a back-to-back frame while the
    //    terminator is still blocked: that frame is dropped
    n0 = wq0.size();
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd3), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 1, 1, 1);
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 1);
    beat(hdr1(ETHERTYPE, 2'd2), 8'hFF, 0, 0, 1);
    beat(P2, 8'hFF, 1, 1, 1);
    idle(3, 1'b0);
    check("blk_nwrites", 76'(wq0.size() - n0), 76'd2);
    check("blk_term", wq0[n0+1], {2'd3, 1'b1, 1'b1, 8'h00, 64'h0});
    check("blk_drop", {44'd0, drop0}, 76'd6);
    check("blk_ovf", {44'd0, ovf0}, 76'd2);

    // 7. back-to-back good frames (2 payload beats, then the 3-beat minimum)
    n0 = wq0.size();
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd0), 8'hFF, 0, 0, 0);
    beat(P0, 8'hFF, 0, 0, 0);
    beat(P1, 8'hFF, 1, 1, 0);
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd2), 8'hFF, 0, 0, 0);
    beat(P3, 8'h01, 1, 1, 0);
    idle(2, 1'b0);
    check("b2b_nwrites", 76'(wq0.size() - n0), 76'd3);
    check("b2b_tlast", {73'd0, wq0[n0][72], wq0[n0+1][72], wq0[n0+2][72]}, 76'b011);
    check("b2b_second", wq0[n0+2], {2'd2, 1'b0, 1'b1, 8'h01, P3});
    check("b2b_ok", {44'd0, ok0}, 76'd3);

    // reset pulse during idle
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);
    check("post_rst_cnts", {ok0[7:0], drop0[7:0], ovf0[7:0], ok1[7:0], drop1[7:0], ovf1[7:0]}, 76'd0);
    check("post_rst_wr_en", {75'd0, bus0.wr_en}, 76'd0);
    check("post_rst_din", bus0.din, 76'd0);

    // a frame after reset still works
    beat(hdr0(LOCAL_MAC), 8'hFF, 0, 0, 0);
    beat(hdr1(ETHERTYPE, 2'd1), 8'hFF, 0, 0, 0);
    beat(P2, 8'hFF, 1, 1, 0);
    idle(3, 1'b0);
    check("post_rst_ok", {44'd0, ok0}, 76'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
